// File: rtl/debug_unit.sv
`timescale 1ns/1ps
// debug_unit: host-side debug controller for the MIPS pipeline.
// Decodes UART command bytes to load instruction memory, run or single-step
// the pipeline, and stream a 38-byte snapshot of the pipeline debug buses
// back to the UART transmitter.
// Optional build macro DU_LOAD_ACK_EN: when defined, every load (including
// an empty one) ends by transmitting an acknowledge byte 'K' (0x4B).
module debug_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8,
    parameter int NB_FRAME = 304
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_tx_done,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_start,
    input  logic                i_end,
    input  logic [15:0]         i_pc,
    input  logic [23:0]         i_control,
    input  logic [143:0]        i_id_ex,
    input  logic [31:0]         i_ex_mem,
    input  logic [47:0]         i_mem_wb,
    input  logic [39:0]         i_wb,
    output logic                o_we_if,
    output logic [NB_DATA-1:0]  o_inst_data,
    output logic [NB_DATA-1:0]  o_inst_addr,
    output logic                o_halt,
    output logic                o_busy
);

    localparam int FRAME_BYTES = NB_FRAME / NB_BYTE;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(8'h44);
`ifdef DU_LOAD_ACK_EN
    localparam logic [NB_BYTE-1:0] ACK_BYTE = NB_BYTE'(8'h4B);
`endif

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CNT,
        LOAD_BYTE,
        LOAD_WR,
        RUN,
        STEP,
        SNAP,
        TX_SEND,
        TX_WAIT
`ifdef DU_LOAD_ACK_EN
        ,
        ACK
`endif
    } state_t;

    state_t                 state;
    logic [NB_BYTE-1:0]     word_cnt;
    logic [NB_BYTE-1:0]     word_idx;
    logic [1:0]             byte_cnt;
    logic [5:0]             tx_cnt;
    logic [NB_FRAME-1:0]    frame;

    logic                   halt;
    logic                   we_if;
    logic [NB_DATA-1:0]     inst_data;
    logic [NB_DATA-1:0]     inst_addr;
    logic                   tx_start;
    logic [NB_BYTE-1:0]     tx_data;

    // Command FSM: all outputs are registered and updated together with the state.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            tx_cnt    <= '0;
            frame     <= '0;
            halt      <= 1'b1;
            we_if     <= 1'b0;
            inst_data <= '0;
            inst_addr <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            we_if    <= 1'b0;
            tx_start <= 1'b0;

            case (state)
                IDLE: begin
                    halt <= 1'b1;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: state <= LOAD_CNT;
                            // Halt release is decided on the entry edge so a finished
                            // program never sees a spurious run cycle.
                            CMD_CONT: begin
                                if (i_end) begin
                                    state <= SNAP;
                                end else begin
                                    halt  <= 1'b0;
                                    state <= RUN;
                                end
                            end
                            CMD_STEP: begin
                                if (i_end) begin
                                    state <= SNAP;
                                end else begin
                                    halt  <= 1'b0;
                                    state <= STEP;
                                end
                            end
                            CMD_DUMP: state <= SNAP;
                            default:  state <= IDLE;
                        endcase
                    end
                end

                LOAD_CNT: begin
                    halt <= 1'b1;
                    if (i_rx_valid) begin
                        word_cnt <= i_rx_data;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        if (i_rx_data == '0) begin
`ifdef DU_LOAD_ACK_EN
                            tx_data  <= ACK_BYTE;
                            tx_start <= 1'b1;
                            state    <= ACK;
`else
                            state    <= IDLE;
`endif
                        end else begin
                            state <= LOAD_BYTE;
                        end
                    end
                end

                LOAD_BYTE: begin
                    halt <= 1'b1;
                    if (i_rx_valid) begin
                        inst_data <= {inst_data[NB_DATA-NB_BYTE-1:0], i_rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we_if     <= 1'b1;
                            inst_addr <= {{(NB_DATA-NB_BYTE-2){1'b0}}, word_idx, 2'b00};
                            state     <= LOAD_WR;
                        end
                    end
                end

                LOAD_WR: begin
                    halt     <= 1'b1;
                    word_idx <= word_idx + NB_BYTE'(1);
                    if (word_idx == word_cnt - NB_BYTE'(1)) begin
`ifdef DU_LOAD_ACK_EN
                        tx_data  <= ACK_BYTE;
                        tx_start <= 1'b1;
                        state    <= ACK;
`else
                        state    <= IDLE;
`endif
                    end else begin
                        state <= LOAD_BYTE;
                    end
                end

                RUN: begin
                    if (i_end) begin
                        halt  <= 1'b1;
                        state <= SNAP;
                    end else begin
                        halt <= 1'b0;
                    end
                end

                STEP: begin
                    halt  <= 1'b1;
                    state <= SNAP;
                end

                SNAP: begin
                    halt   <= 1'b1;
                    frame  <= {i_pc, i_control, i_id_ex, i_ex_mem, i_mem_wb, i_wb};
                    tx_cnt <= '0;
                    state  <= TX_SEND;
                end

                // The shadow frame is shifted left after each byte, so the next byte
                // to send is always the top byte.
                TX_SEND: begin
                    halt     <= 1'b1;
                    tx_data  <= frame[NB_FRAME-1 -: NB_BYTE];
                    tx_start <= 1'b1;
                    state    <= TX_WAIT;
                end

                TX_WAIT: begin
                    halt <= 1'b1;
                    if (i_tx_done) begin
                        frame  <= frame << NB_BYTE;
                        tx_cnt <= tx_cnt + 6'd1;
                        if (tx_cnt == 6'(FRAME_BYTES - 1)) begin
                            state <= IDLE;
                        end else begin
                            state <= TX_SEND;
                        end
                    end
                end

`ifdef DU_LOAD_ACK_EN
                ACK: begin
                    halt <= 1'b1;
                    if (i_tx_done) begin
                        state <= IDLE;
                    end
                end
`endif

                default: begin
                    halt  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_halt      = halt;
    assign o_we_if     = we_if;
    assign o_inst_data = inst_data;
    assign o_inst_addr = inst_addr;
    assign o_tx_start  = tx_start;
    assign o_tx_data   = tx_data;
    assign o_busy      = (state != IDLE);

endmodule
